// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder.
package mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W.
// The registered read port holds its value and can only be loaded or cleared.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the CPU memory stage.
// Optional bounds checking: MEM_BOUNDS_CHECK_EN. Read data leaves on dout ("do" is a reserved word).
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic              err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LOAD  = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_wr;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_di;

  logic              accept_c;
  logic              in_wait_c;
  logic              enter_resp_c;
  logic              cur_wr_c;
  logic              oob_c;
  logic [IDX_W-1:0]  cur_idx_c;
  logic [DATA_W-1:0] cur_di_c;
  logic              ram_we_c;
  logic              ram_re_c;
  logic              ram_clr_c;

`ifdef MEM_BOUNDS_CHECK_EN
  logic cap_oob;
  logic addr_oob_c;

  assign addr_oob_c = (addr >= ADDR_W'(DEPTH));
`else
  logic unused_addr_c;

  assign unused_addr_c = ^addr[ADDR_W-1:IDX_W];
  assign err           = 1'b0;
`endif

  // The RAM is driven from the live request when LATENCY=1, else from the captured one.
  always_comb begin
    accept_c     = 1'b0;
    in_wait_c    = 1'b0;
    enter_resp_c = 1'b0;
    cur_wr_c     = wr;
    cur_idx_c    = addr[IDX_W-1:0];
    cur_di_c     = di;
    oob_c        = 1'b0;

    accept_c  = req && ((state == IDLE) || (state == RESP));
    in_wait_c = (state == WAIT);
    if (in_wait_c) begin
      enter_resp_c = (cnt == '0);
      cur_wr_c     = cap_wr;
      cur_idx_c    = cap_idx;
      cur_di_c     = cap_di;
    end else begin
      enter_resp_c = accept_c && (LATENCY == 1);
    end
`ifdef MEM_BOUNDS_CHECK_EN
    oob_c = in_wait_c ? cap_oob : addr_oob_c;
`endif
  end

  assign ram_we_c  = !rst && enter_resp_c && cur_wr_c && !oob_c;
  assign ram_re_c  = !rst && enter_resp_c && !cur_wr_c && !oob_c;
  assign ram_clr_c = rst || (enter_resp_c && !cur_wr_c && oob_c);

  // Request sequencing: IDLE/RESP accept, WAIT counts down the latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      valid <= enter_resp_c;
`ifdef MEM_BOUNDS_CHECK_EN
      err   <= enter_resp_c && oob_c;
`endif
      case (state)
        IDLE, RESP: begin
          if (req) begin
            cap_wr  <= wr;
            cap_idx <= addr[IDX_W-1:0];
            cap_di  <= di;
`ifdef MEM_BOUNDS_CHECK_EN
            cap_oob <= addr_oob_c;
`endif
            if (LATENCY == 1) begin
              state <= RESP;
              busy  <= 1'b0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LOAD);
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            busy  <= 1'b0;
          end else begin
            cnt   <= cnt - CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .clr   (ram_clr_c),
    .idx   (cur_idx_c),
    .wdata (cur_di_c),
    .rdata (dout)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (LATENCY 1..4, DEPTH 16) share one directed stimulus
// and are checked every cycle against a transaction-level model, plus hand-computed spot values.
module tb_mem_responder;

  localparam int unsigned NDUT  = 4;
  localparam int unsigned DEPTH = 16;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [15:0] di;

  logic [NDUT-1:0]       busy_v;
  logic [NDUT-1:0]       valid_v;
  logic [NDUT-1:0]       err_v;
  logic [NDUT-1:0][15:0] do_v;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (g + 1)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .wr    (wr),
      .addr  (addr),
      .di    (di),
      .busy  (busy_v[g]),
      .valid (valid_v[g]),
      .dout  (do_v[g]),
      .err   (err_v[g])
    );
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Transaction model: one outstanding request per instance, timed from its acceptance edge.
  logic [15:0] mm    [NDUT][DEPTH];
  bit          pend  [NDUT];
  int          pedge [NDUT];
  bit          pwr   [NDUT];
  logic [31:0] paddr [NDUT];
  logic [15:0] pdi   [NDUT];
  bit          ev    [NDUT];
  bit          eb    [NDUT];
  bit          ee    [NDUT];
  logic [15:0] ed    [NDUT];

  int vcnt [NDUT];
  int bcnt [NDUT];
  int ecnt [NDUT];
  int run  [NDUT];
  int last_run [NDUT];
  int v0 [NDUT];
  int b0 [NDUT];
  int e0 [NDUT];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d (L=%0d) at edge %0d: got %h expected %h", name, k, k + 1, edge_n, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      int lat;
      bit oob;
      lat = k + 1;
      if (rst) begin
        pend[k] = 1'b0;
        ev[k]   = 1'b0;
        eb[k]   = 1'b0;
        ee[k]   = 1'b0;
        ed[k]   = 16'h0000;
      end else begin
        ev[k] = 1'b0;
        ee[k] = 1'b0;
        if (req && (!pend[k] || edge_n >= pedge[k] + lat)) begin
          pend[k]  = 1'b1;
          pedge[k] = edge_n;
          pwr[k]   = wr;
          paddr[k] = addr;
          pdi[k]   = di;
        end
        if (pend[k] && edge_n == pedge[k] + lat - 1) begin
          oob   = BOUNDS && (paddr[k] >= DEPTH);
          ev[k] = 1'b1;
          ee[k] = oob;
          if (pwr[k]) begin
            if (!oob) mm[k][paddr[k] % DEPTH] = pdi[k];
          end else begin
            ed[k] = oob ? 16'h0000 : mm[k][paddr[k] % DEPTH];
          end
        end
        eb[k] = pend[k] && (edge_n < pedge[k] + lat - 1);
      end
    end
  endtask

  // One clock: update the model at the edge, compare just after it, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("valid", k, valid_v[k], ev[k]);
      check("busy", k, busy_v[k], eb[k]);
      check("err", k, err_v[k], ee[k]);
      check("do", k, do_v[k], ed[k]);
      check("valid_and_busy", k, valid_v[k] & busy_v[k], 0);
      vcnt[k] += int'(valid_v[k]);
      bcnt[k] += int'(busy_v[k]);
      ecnt[k] += int'(err_v[k]);
      if (valid_v[k]) begin
        run[k]++;
      end else if (run[k] > 0) begin
        last_run[k] = run[k];
        run[k] = 0;
      end
    end
    edge_n++;
    @(negedge clk);
  endtask

  task automatic pulse(input bit w, input logic [31:0] a, input logic [15:0] d);
    req  = 1'b1;
    wr   = w;
    addr = a;
    di   = d;
    tick();
    req  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    v0 = vcnt;
    b0 = bcnt;
    e0 = ecnt;
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      vcnt[k] = 0; bcnt[k] = 0; ecnt[k] = 0; run[k] = 0; last_run[k] = 0;
      pend[k] = 1'b0; pedge[k] = 0;
    end
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; di = '0;
    idle(2);
    for (int k = 0; k < NDUT; k++) begin
      check("reset_do", k, do_v[k], 32'h0000);
      check("reset_busy", k, busy_v[k], 0);
      check("reset_valid", k, valid_v[k], 0);
    end
    rst = 1'b0;
    idle(1);

    // Seed known contents.
    foreach (v0[i]) v0[i] = 0;
    for (int a = 0; a < 8; a++) begin
      if (a != 4 && a != 6) begin
        pulse(1'b1, 32'(a), 16'h1000 + 16'(a));
        idle(5);
      end
    end

    // Latency 2: write then read of word 5.
    snap();
    pulse(1'b1, 32'd5, 16'hBEEF);
    check("l2_busy_after_accept", 1, busy_v[1], 1);
    tick();
    check("l2_write_valid", 1, valid_v[1], 1);
    idle(5);
    check("l2_write_valids", 1, vcnt[1] - v0[1], 1);
    check("l2_write_busy_cycles", 1, bcnt[1] - b0[1], 1);
    snap();
    pulse(1'b0, 32'd5, 16'h0000);
    idle(6);
    check("l2_read_do", 1, do_v[1], 32'hBEEF);
    check("l2_read_busy_cycles", 1, bcnt[1] - b0[1], 1);

    // Latency 1: req held for four reads of words 0..3.
    snap();
    req = 1'b1; wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i);
      tick();
    end
    req = 1'b0;
    idle(8);
    check("l1_valids", 0, vcnt[0] - v0[0], 4);
    check("l1_consecutive", 0, last_run[0], 4);
    check("l1_busy_never", 0, bcnt[0] - b0[0], 0);
    check("l1_last_do", 0, do_v[0], 32'h1003);
    check("l2_held_req_do", 1, do_v[1], 32'h1002);

    // Latency 3: req while busy is ignored, re-assert at the RESP edge is taken.
    snap();
    pulse(1'b0, 32'd1, 16'h0000);
    pulse(1'b0, 32'd2, 16'h0000);
    idle(6);
    check("l3_ignored_valids", 2, vcnt[2] - v0[2], 1);
    check("l3_ignored_do", 2, do_v[2], 32'h1001);
    snap();
    pulse(1'b0, 32'd1, 16'h0000);
    idle(2);
    pulse(1'b0, 32'd3, 16'h0000);
    idle(6);
    check("l3_resp_accept_valids", 2, vcnt[2] - v0[2], 2);
    check("l3_resp_accept_do", 2, do_v[2], 32'h1003);
    check("l4_in_wait_do", 3, do_v[3], 32'h1001);

    // Latency 4: reset two cycles after a write is accepted.
    snap();
    pulse(1'b1, 32'd7, 16'hDEAD);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(4);
    check("l4_abandoned_valids", 3, vcnt[3] - v0[3], 0);
    check("l4_reset_do", 3, do_v[3], 32'h0000);
    pulse(1'b0, 32'd7, 16'h0000);
    idle(6);
    check("l4_prior_contents", 3, do_v[3], 32'h1007);
    check("l2_committed_before_rst", 1, do_v[1], 32'hDEAD);

    // Out-of-range address 16 against word 0.
    snap();
    pulse(1'b1, 32'd16, 16'h1234);
    idle(5);
    check("oob_write_valids", 1, vcnt[1] - v0[1], 1);
    check("oob_err_pulses", 1, ecnt[1] - e0[1], BOUNDS ? 1 : 0);
    pulse(1'b0, 32'd0, 16'h0000);
    idle(6);
    check("word0_after_oob", 1, do_v[1], BOUNDS ? 32'h1000 : 32'h1234);
    snap();
    pulse(1'b0, 32'd16, 16'h0000);
    idle(6);
    check("oob_read_do", 1, do_v[1], BOUNDS ? 32'h0000 : 32'h1234);
    check("oob_read_err", 1, ecnt[1] - e0[1], BOUNDS ? 1 : 0);

    // Read accepted on the edge ending a write's RESP sees the new data.
    req = 1'b1; wr = 1'b1; addr = 32'd9; di = 16'hA5A5;
    tick();
    wr = 1'b0;
    tick();
    tick();
    req = 1'b0;
    idle(6);
    check("l2_wr_then_rd", 1, do_v[1], 32'hA5A5);
    check("l1_wr_then_rd", 0, do_v[0], 32'hA5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
